button_debounce: RTL

Conditions one raw push-button input (BUT[n]) into a clean, glitch-free level plus single-cycle press, release and auto-repeat pulses. It sits between the board button pins and consumer blocks such as the LED driver on PMOD[55] in the chip top level. It runs in the 100 MHz clk domain and contains a 2-flop synchroniser, a debounce counter and a hold/auto-repeat timer.

---
 rtl/button_debounce.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: polarity fix, 2-flop synchroniser, debounce
// counter and hold/auto-repeat timer.
//
// Ports
//   clk          system clock (100 MHz)
//   rst          synchronous active-high reset
//   but_in       raw asynchronous button pin
//   btn_level    debounced pressed state, 1 = pressed
//   btn_press    one-cycle pulse when btn_level rises
//   btn_release  one-cycle pulse when btn_level falls
//   btn_repeat   one-cycle auto-repeat pulse while the button is held
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic but_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int unsigned TMR_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
    localparam bit          REPEAT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD_DELAY,
        ST_REPEATING
    } state_t;

    logic             raw_c;
    logic [1:0]       sync_q;
    logic             sync_c;
    logic             differ_c;
    logic             toggle_c;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    logic [TMR_W-1:0] tmr_q;
    state_t           state_q;

    // Polarity correction happens ahead of the synchroniser
    assign raw_c  = but_in ^ ACTIVE_LOW;
    assign sync_c = sync_q[1];

    // Debounce: count consecutive cycles the synchronised input disagrees
    // with the debounced level; toggle on the last of DEBOUNCE_CYCLES.
    always_comb begin
        differ_c  = (sync_c != level_q);
        toggle_c  = differ_c && (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));
        deb_cnt_d = '0;
        level_d   = level_q;
        if (toggle_c) begin
            level_d = ~level_q;
        end else if (differ_c) begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    // Synchroniser, debounce state and edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b00;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw_c};
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= toggle_c & ~level_q;
            release_q <= toggle_c & level_q;
        end
    end

    // Hold/auto-repeat FSM. The timer reads 1 in the press cycle, so a
    // match against the delay/period lands the pulse exactly that many
    // cycles after the reference pulse. A release on the expiry edge wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tmr_q <= '0;
                    if (REPEAT_EN && toggle_c && !level_q) begin
                        state_q <= ST_HOLD_DELAY;
                        tmr_q   <= TMR_W'(1);
                    end
                end
                ST_HOLD_DELAY: begin
                    if (toggle_c) begin
                        state_q <= ST_IDLE;
                        tmr_q   <= '0;
                    end else if (tmr_q == TMR_W'(REPEAT_DELAY)) begin
                        state_q  <= ST_REPEATING;
                        repeat_q <= 1'b1;
                        tmr_q    <= TMR_W'(1);
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_REPEATING: begin
                    if (toggle_c) begin
                        state_q <= ST_IDLE;
                        tmr_q   <= '0;
                    end else if (tmr_q == TMR_W'(REPEAT_PERIOD)) begin
                        repeat_q <= 1'b1;
                        tmr_q    <= TMR_W'(1);
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tmr_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule
